// File: rtl/bcd_result_unpack.sv
`timescale 1ns/1ps
// bcd_result_unpack
// Sequential binary-to-BCD converter (shift-add-3 / double-dabble), one
// input bit per clock, with a start/busy/done handshake.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   conversion request, accepted only while busy=0
//   bin    in   IN_W-bit binary value, sampled on the accepted start cycle
//   busy   out  high while shifting
//   done   out  one-cycle pulse when D1..D4/ovf update
//   D1..D4 out  BCD digits, D1 most significant
//   ovf    out  last converted value exceeded 10^NDIG-1
//
// Optional feature macro: LEAD_ZERO_BLANK_EN
//   When defined, leading zero digits (D1 downward, never D4) are output as
//   4'hF in non-overflow results.
module bcd_result_unpack #(
    parameter int unsigned IN_W = 14,
    parameter int unsigned NDIG = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [IN_W-1:0] bin,
    output logic            busy,
    output logic            done,
    output logic [3:0]      D1,
    output logic [3:0]      D2,
    output logic [3:0]      D3,
    output logic [3:0]      D4,
    output logic            ovf
);

    localparam int unsigned SCR_W = 4 * (NDIG + 1);
    localparam int unsigned CNT_W = $clog2(IN_W + 1);
    localparam int unsigned LIMIT = 10 ** NDIG - 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                 r_state,    w_state_nxt;
    logic [SCR_W-1:0]       r_scratch,  w_scratch_nxt;
    logic [IN_W-1:0]        r_shreg,    w_shreg_nxt;
    logic [CNT_W-1:0]       r_cnt,      w_cnt_nxt;
    logic                   r_ovf_next, w_ovf_next_nxt;
    logic                   r_busy,     w_busy_nxt;
    logic                   r_done,     w_done_nxt;
    logic [NDIG-1:0][3:0]   r_d,        w_d_nxt;
    logic                   r_ovf,      w_ovf_nxt;

    logic [SCR_W-1:0]       w_adj;
    logic [SCR_W-1:0]       w_shift_scr;
    logic [NDIG-1:0][3:0]   w_raw;
    logic [NDIG-1:0][3:0]   w_out;
`ifdef LEAD_ZERO_BLANK_EN
    logic                   w_lead;
`endif

    // Add-3 correction on every scratch digit that would overflow on doubling
    for (genvar g = 0; g < NDIG + 1; g++) begin : g_adj
        assign w_adj[4*g +: 4] = (r_scratch[4*g +: 4] >= 4'd5) ?
                                 r_scratch[4*g +: 4] + 4'd3 :
                                 r_scratch[4*g +: 4];
    end

    // Scratch after the shift; the top scratch bit falls off (always 0 for IN_W=14)
    assign w_shift_scr = SCR_W'({w_adj, r_shreg[IN_W-1]});
    assign w_raw       = w_shift_scr[4*NDIG-1:0];

    // Final digit formatting: saturate on overflow, optionally blank leading zeros
    always_comb begin
        w_out = w_raw;
`ifdef LEAD_ZERO_BLANK_EN
        w_lead = 1'b1;
        for (int i = NDIG - 1; i > 0; i--) begin
            if (w_lead && (w_raw[i] == 4'd0)) begin
                w_out[i] = 4'hF;
            end else begin
                w_lead = 1'b0;
            end
        end
`endif
        if (r_ovf_next) begin
            w_out = {NDIG{4'd9}};
        end
    end

    // State register and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_scratch  <= '0;
            r_shreg    <= '0;
            r_cnt      <= '0;
            r_ovf_next <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_d        <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_scratch  <= w_scratch_nxt;
            r_shreg    <= w_shreg_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ovf_next <= w_ovf_next_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_d        <= w_d_nxt;
            r_ovf      <= w_ovf_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt    = r_state;
        w_scratch_nxt  = r_scratch;
        w_shreg_nxt    = r_shreg;
        w_cnt_nxt      = r_cnt;
        w_ovf_next_nxt = r_ovf_next;
        w_busy_nxt     = 1'b0;
        w_done_nxt     = 1'b0;
        w_d_nxt        = r_d;
        w_ovf_nxt      = r_ovf;

        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_IDLE;
            end
            S_SHIFT: begin
                w_scratch_nxt = w_shift_scr;
                w_shreg_nxt   = {r_shreg[IN_W-2:0], 1'b0};
                w_cnt_nxt     = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    // Last bit shifted: publish results so they are valid in DONE
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                    w_d_nxt     = w_out;
                    w_ovf_nxt   = r_ovf_next;
                end else begin
                    w_busy_nxt  = 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Accept a new request from IDLE or DONE (back-to-back)
        if (start && (r_state == S_IDLE || r_state == S_DONE)) begin
            w_state_nxt    = S_SHIFT;
            w_busy_nxt     = 1'b1;
            w_shreg_nxt    = bin;
            w_scratch_nxt  = '0;
            w_cnt_nxt      = CNT_W'(IN_W);
            w_ovf_next_nxt = (32'(bin) > LIMIT);
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign D1   = r_d[3];
    assign D2   = r_d[2];
    assign D3   = r_d[1];
    assign D4   = r_d[0];
    assign ovf  = r_ovf;

endmodule

// File: doc/bcd_result_unpack.md
Name: bcd_result_unpack

Overview:
- Sequential binary-to-BCD converter for the calculator datapath; the reverse of the digit-to-number packing that feeds the arithmetic units.
- Takes a 14-bit binary result from the divide/multiply/add units and unpacks it into four BCD digits for the display driver.
- Uses an iterative shift-add-3 (double-dabble) scheme, one input bit per clock, with a start/busy/done handshake.

Parameters:
- IN_W, 14, width of the binary input.
- NDIG, 4, number of BCD output digits. Internal scratch holds NDIG+1 digits.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request conversion of bin. Sampled only when busy=0.
- bin  input  IN_W  binary value to convert. Sampled on the accepted start cycle only.
- busy  output  1  high while shifting.
- done  output  1  single-cycle pulse when D1..D4/ovf are updated.
- D1  output  4  thousands digit (most significant).
- D2  output  4  hundreds digit.
- D3  output  4  tens digit.
- D4  output  4  units digit.
- ovf  output  1  high when the last converted value exceeded 10^NDIG-1.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0; done=0; D1..D4=0; ovf=0; scratch and counter cleared. Deassertion is synchronous to clk.
- States:
  - IDLE: busy=0. start=1 loads bin into the shift register, clears BCD scratch, sets bit counter=IN_W, latches ovf_next=(bin>10^NDIG-1), then goes to SHIFT.
  - SHIFT: busy=1. Each cycle:
    - every scratch digit >=5 gets +3;
    - {scratch,shreg} shifts left 1;
    - counter decrements.
    - When the counter reaches 0 after the shift, go to DONE.
  - DONE: busy=0, done=1 for exactly this cycle. D1..D4 and ovf are registered here. Next state is IDLE, or SHIFT if start=1 (back-to-back accept, same load action as IDLE).
- Latency: accepted start at cycle 0 -> IN_W SHIFT cycles (1..14) -> done and outputs valid at cycle 15. Throughput is one conversion per 15 cycles with back-to-back starts.
- start while busy=1 is ignored, with no queuing. Changes on bin while busy do not affect the result.
- Overflow: if ovf_next=1, D1..D4=9,9,9,9 and ovf=1. Otherwise D1..D4 are the low NDIG scratch digits and ovf=0.
- Outputs hold their last values between done pulses. They change only in the DONE cycle or on reset.
- Reset mid-SHIFT aborts the conversion immediately and applies the reset values. No done pulse is issued.
- Every output digit is in 0..9 in all non-reset states, except when the optional blanking code applies.

Optional Feature:
- Macro: LEAD_ZERO_BLANK_EN.
- Defined: in the DONE cycle, each leading zero digit from D1 downward is replaced by 4'hF (blank code for the display driver). D4 is never blanked, so 0 shows as F,F,F,0. Blanking does not apply when ovf=1.
- Undefined: leading zeros are output as 0. No 4'hF is ever produced.

Test Plan:
- Reset, then start with bin=1234 -> busy high cycles 1..14; done pulse at cycle 15; D1..D4=1,2,3,4; ovf=0.
- bin=0, then bin=9999 back-to-back (second start asserted in the DONE cycle) -> first done gives 0,0,0,0; second done exactly 15 cycles later gives 9,9,9,9; ovf=0 both times.
- bin=10000, then bin=16383 -> each gives ovf=1 and D1..D4=9,9,9,9. A following bin=5 gives ovf=0 and 0,0,0,5.
- start=1 held continuously, with bin changed from 42 to 77 at cycle 5 -> first result is 0,0,4,2 (second start accepted in DONE, loading 77); no extra done pulses.
- Reset asserted at cycle 7 of a conversion of bin=8765 -> all outputs 0 immediately and no done pulse. Next start with bin=321 -> 0,3,2,1 after 15 cycles.
- With LEAD_ZERO_BLANK_EN defined: bin=42 -> F,F,4,2; bin=0 -> F,F,F,0; bin=10000 -> 9,9,9,9 with ovf=1.
